ddr2_ras_csr_gen2: RTL and testbench

//  Second-generation RAS status/control block for the DDR2 controller. Counts ECC corrected
//  and uncorrected errors per rank, with saturation and leaky-bucket decay. Logs error context
//  in a FIFO and raises maskable W1C interrupts. Has a read/write CSR port. Sits beside the ECC

---
 rtl/ddr2_ras_pkg.sv | 43 ++++
 rtl/ddr2_ras_log_fifo.sv | 64 ++++++
 rtl/ddr2_ras_csr_gen2.sv | 252 +++++++++++++++++++++++++
 tb/tb_ddr2_ras_csr_gen2.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_ras_pkg.sv
// Shared constants and types for the DDR2 RAS status/control block: register map,
// STATUS bit positions, log-entry metadata and reset values.
package ddr2_ras_pkg;

   localparam logic [7:0] AddrTotalCorr   = 8'h00;
   localparam logic [7:0] AddrTotalUncorr = 8'h04;
   localparam logic [7:0] AddrLogInfo     = 8'h08;
   localparam logic [7:0] AddrLogAddr     = 8'h0C;
   localparam logic [7:0] AddrCorrThresh  = 8'h10;
   localparam logic [7:0] AddrDecayPeriod = 8'h14;
   localparam logic [7:0] AddrScrubCount  = 8'h18;
   localparam logic [7:0] AddrIrqMask     = 8'h1C;
   localparam logic [7:0] AddrStatus      = 8'h20;
   localparam logic [7:0] AddrLogPop      = 8'h24;
   localparam logic [7:0] AddrCtrl        = 8'h28;
   localparam logic [7:0] AddrRankCorr    = 8'h40;
   localparam logic [7:0] AddrRankUncorr  = 8'h80;

   localparam int unsigned StatusW     = 4;
   localparam int unsigned StatCorrThr = 0;
   localparam int unsigned StatUncorr  = 1;
   localparam int unsigned StatLogOvf  = 2;
   localparam int unsigned StatLogDrop = 3;
   localparam int unsigned StatFatal   = 31;
   localparam int unsigned CtrlClrBit  = 0;

   localparam logic [31:0] CorrThreshRst  = 32'd1000;
   localparam logic [31:0] DecayPeriodRst = 32'd0;
   localparam logic [1:0]  IrqMaskRst     = 2'b11;

   typedef struct packed {
      logic       dbl;
      logic [3:0] rank;
      logic [7:0] syndrome;
   } log_meta_t;

   localparam int unsigned LogMetaW = $bits(log_meta_t);

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ddr2_ras_log_fifo.sv
// Synchronous FIFO for the RAS error log; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module ddr2_ras_log_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 38
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [Width-1:0]       wdata_i,
   output logic [Width-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] level_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [LvlW-1:0] FullLvl = Depth[LvlW-1:0];

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LvlW-1:0]  level_q, level_d;
   logic             push_ok, pop_ok;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == FullLvl);
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   always_comb begin
      wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
      level_d = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LvlW'(1);
      end else if (pop_ok && !push_ok) begin
         level_d = level_q - LvlW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: the level alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/ddr2_ras_csr_gen2.sv
// DDR2 RAS status/control: per-rank ECC counters with saturation and decay, error log,
// maskable W1C interrupts and a CSR read/write port.
module ddr2_ras_csr_gen2
   import ddr2_ras_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 25,
   parameter int unsigned NUM_RANKS  = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned LOG_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ecc_single_err,
   input  logic                  ecc_double_err,
   input  logic [7:0]            ecc_syndrome,
   input  logic [ADDR_WIDTH-1:0] err_addr,
   input  logic [3:0]            err_rank,
   input  logic                  scrub_active,
   input  logic                  csr_valid,
   input  logic                  csr_write,
   input  logic [7:0]            csr_addr,
   input  logic [31:0]           csr_wdata,
   output logic                  csr_ready,
   output logic                  csr_rdata_valid,
   output logic [31:0]           csr_rdata,
   output logic                  irq_ecc_corr,
   output logic                  irq_ecc_uncorr,
   output logic [NUM_RANKS-1:0]  rank_degraded,
   output logic                  fatal_error
);

   localparam int unsigned LogW = LogMetaW + ADDR_WIDTH;
   localparam int unsigned LvlW = $clog2(LOG_DEPTH) + 1;

   logic                 csr_ready_q, rdata_valid_q, rdata_valid_d;
   logic [31:0]          rdata_q, rdata_d, rd_mux;
   logic [31:0]          total_corr_q, total_corr_d, total_uncorr_q, total_uncorr_d;
   logic [CNT_WIDTH-1:0] corr_cnt_q [NUM_RANKS];
   logic [CNT_WIDTH-1:0] corr_cnt_d [NUM_RANKS];
   logic [CNT_WIDTH-1:0] uncorr_cnt_q [NUM_RANKS];
   logic [CNT_WIDTH-1:0] uncorr_cnt_d [NUM_RANKS];
   logic [31:0]          corr_thresh_q, corr_thresh_d, decay_period_q, decay_period_d;
   logic [31:0]          decay_cnt_q, decay_cnt_d, scrub_cnt_q, scrub_cnt_d;
   logic [1:0]           irq_mask_q, irq_mask_d;
   logic [StatusW-1:0]   status_q, status_d, stat_set, stat_clr;
   logic                 fatal_q, fatal_d, irq_corr_q, irq_corr_d, irq_uncorr_q, irq_uncorr_d;
   logic [NUM_RANKS-1:0] degraded_q, degraded_d, degraded_set;
   logic                 thr_set;

   logic req_rd, req_wr, wr_thresh, wr_decay, wr_mask, wr_status, wr_pop, ctrl_clr;
   logic decay_tick;

   logic            log_push, log_full, log_empty;
   logic [LogW-1:0] log_head;
   logic [LvlW-1:0] log_level;
   log_meta_t       push_meta, head_meta;
   logic [31:0]     log_info, log_addr_rd;

   assign req_rd    = csr_valid && csr_ready_q && !csr_write;
   assign req_wr    = csr_valid && csr_ready_q && csr_write;
   assign wr_thresh = req_wr && (csr_addr == AddrCorrThresh);
   assign wr_decay  = req_wr && (csr_addr == AddrDecayPeriod);
   assign wr_mask   = req_wr && (csr_addr == AddrIrqMask);
   assign wr_status = req_wr && (csr_addr == AddrStatus);
   assign wr_pop    = req_wr && (csr_addr == AddrLogPop);
   assign ctrl_clr  = req_wr && (csr_addr == AddrCtrl) && csr_wdata[CtrlClrBit];

   assign decay_tick = (decay_period_q != 32'd0) && (decay_cnt_q == decay_period_q - 32'd1);

   // Double wins the single log slot when both strobes fire together.
   assign log_push  = ecc_single_err || ecc_double_err;
   assign push_meta = '{dbl: ecc_double_err, rank: err_rank, syndrome: ecc_syndrome};

   ddr2_ras_log_fifo #(
      .Depth(LOG_DEPTH),
      .Width(LogW)
   ) u_log_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (log_push),
      .pop_i  (wr_pop),
      .wdata_i({push_meta, err_addr}),
      .rdata_o(log_head),
      .full_o (log_full),
      .empty_o(log_empty),
      .level_o(log_level)
   );

   assign head_meta = log_meta_t'(log_head[ADDR_WIDTH +: LogMetaW]);

   always_comb begin
      log_info    = 32'd0;
      log_addr_rd = 32'd0;
      if (!log_empty) begin
         log_info    = {1'b1, head_meta.dbl, 2'b00, 4'(log_level), 12'd0,
                        head_meta.rank, head_meta.syndrome};
         log_addr_rd = 32'(log_head[ADDR_WIDTH-1:0]);
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (csr_addr)
         AddrTotalCorr:   rd_mux = total_corr_q;
         AddrTotalUncorr: rd_mux = total_uncorr_q;
         AddrLogInfo:     rd_mux = log_info;
         AddrLogAddr:     rd_mux = log_addr_rd;
         AddrCorrThresh:  rd_mux = corr_thresh_q;
         AddrDecayPeriod: rd_mux = decay_period_q;
         AddrScrubCount:  rd_mux = scrub_cnt_q;
         AddrIrqMask:     rd_mux = {30'd0, irq_mask_q};
         AddrStatus: begin
            rd_mux[StatusW-1:0] = status_q;
            rd_mux[StatFatal]   = fatal_q;
         end
         default: ;
      endcase
      for (int r = 0; r < NUM_RANKS; r++) begin
         if (csr_addr == AddrRankCorr + 8'(4 * r)) begin
            rd_mux = 32'(corr_cnt_q[r]);
         end
         if (csr_addr == AddrRankUncorr + 8'(4 * r)) begin
            rd_mux = 32'(uncorr_cnt_q[r]);
         end
      end
   end

   // Counters: CTRL clear is applied before the event, so a coincident error counts as one.
   always_comb begin
      logic [CNT_WIDTH-1:0] base;
      logic                 inc, dec;
      base         = '0;
      inc          = 1'b0;
      dec          = 1'b0;
      thr_set      = 1'b0;
      degraded_set = '0;
      for (int r = 0; r < NUM_RANKS; r++) begin
         base = ctrl_clr ? '0 : corr_cnt_q[r];
         inc  = ecc_single_err && (err_rank == 4'(r));
         dec  = decay_tick && (base != '0);
         corr_cnt_d[r] = base;
         if (inc && !dec) begin
            corr_cnt_d[r] = (&base) ? base : base + CNT_WIDTH'(1);
         end else if (dec && !inc) begin
            corr_cnt_d[r] = base - CNT_WIDTH'(1);
         end
         if (inc && (corr_thresh_q != 32'd0) && (32'(corr_cnt_d[r]) >= corr_thresh_q)) begin
            thr_set         = 1'b1;
            degraded_set[r] = 1'b1;
         end

         base = ctrl_clr ? '0 : uncorr_cnt_q[r];
         inc  = ecc_double_err && (err_rank == 4'(r));
         uncorr_cnt_d[r] = base;
         if (inc) begin
            uncorr_cnt_d[r]  = (&base) ? base : base + CNT_WIDTH'(1);
            degraded_set[r] = 1'b1;
         end
      end

      total_corr_d   = ctrl_clr ? 32'd0 : total_corr_q;
      total_uncorr_d = ctrl_clr ? 32'd0 : total_uncorr_q;
      if (ecc_single_err) begin
         total_corr_d = sat_inc32(total_corr_d);
      end
      if (ecc_double_err) begin
         total_uncorr_d = sat_inc32(total_uncorr_d);
      end
   end

   always_comb begin
      corr_thresh_d  = wr_thresh ? csr_wdata : corr_thresh_q;
      decay_period_d = wr_decay ? csr_wdata : decay_period_q;
      irq_mask_d     = wr_mask ? csr_wdata[1:0] : irq_mask_q;
      scrub_cnt_d    = scrub_active ? sat_inc32(scrub_cnt_q) : scrub_cnt_q;

      if (wr_decay || decay_tick || (decay_period_q == 32'd0)) begin
         decay_cnt_d = 32'd0;
      end else begin
         decay_cnt_d = decay_cnt_q + 32'd1;
      end

      stat_set              = '0;
      stat_set[StatCorrThr] = thr_set;
      stat_set[StatUncorr]  = ecc_double_err;
      stat_set[StatLogOvf]  = log_push && log_full && !wr_pop;
      stat_set[StatLogDrop] = ecc_single_err && ecc_double_err;
      stat_clr              = wr_status ? csr_wdata[StatusW-1:0] : '0;
      status_d              = (status_q & ~stat_clr) | stat_set;

      fatal_d      = fatal_q || ecc_double_err;
      degraded_d   = degraded_q | degraded_set;
      irq_corr_d   = status_q[StatCorrThr] && irq_mask_q[0];
      irq_uncorr_d = status_q[StatUncorr] && irq_mask_q[1];

      rdata_valid_d = req_rd;
      rdata_d       = req_rd ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         csr_ready_q    <= 1'b0;
         rdata_valid_q  <= 1'b0;
         rdata_q        <= 32'd0;
         total_corr_q   <= 32'd0;
         total_uncorr_q <= 32'd0;
         for (int r = 0; r < NUM_RANKS; r++) begin
            corr_cnt_q[r]   <= '0;
            uncorr_cnt_q[r] <= '0;
         end
         corr_thresh_q  <= CorrThreshRst;
         decay_period_q <= DecayPeriodRst;
         decay_cnt_q    <= 32'd0;
         scrub_cnt_q    <= 32'd0;
         irq_mask_q     <= IrqMaskRst;
         status_q       <= '0;
         fatal_q        <= 1'b0;
         degraded_q     <= '0;
         irq_corr_q     <= 1'b0;
         irq_uncorr_q   <= 1'b0;
      end else begin
         csr_ready_q    <= 1'b1;
         rdata_valid_q  <= rdata_valid_d;
         rdata_q        <= rdata_d;
         total_corr_q   <= total_corr_d;
         total_uncorr_q <= total_uncorr_d;
         for (int r = 0; r < NUM_RANKS; r++) begin
            corr_cnt_q[r]   <= corr_cnt_d[r];
            uncorr_cnt_q[r] <= uncorr_cnt_d[r];
         end
         corr_thresh_q  <= corr_thresh_d;
         decay_period_q <= decay_period_d;
         decay_cnt_q    <= decay_cnt_d;
         scrub_cnt_q    <= scrub_cnt_d;
         irq_mask_q     <= irq_mask_d;
         status_q       <= status_d;
         fatal_q        <= fatal_d;
         degraded_q     <= degraded_d;
         irq_corr_q     <= irq_corr_d;
         irq_uncorr_q   <= irq_uncorr_d;
      end
   end

   assign csr_ready       = csr_ready_q;
   assign csr_rdata_valid = rdata_valid_q;
   assign csr_rdata       = rdata_q;
   assign irq_ecc_corr    = irq_corr_q;
   assign irq_ecc_uncorr  = irq_uncorr_q;
   assign rank_degraded   = degraded_q;
   assign fatal_error     = fatal_q;

endmodule

// File: tb/tb_ddr2_ras_csr_gen2.sv
// Directed bench for ddr2_ras_csr_gen2: register-default table plus hand-written sequences
// for thresholds, fatal logging, log overflow, decay timing and coincident events.
module tb_ddr2_ras_csr_gen2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ecc_single_err = 1'b0, ecc_double_err = 1'b0;
   logic [7:0]  ecc_syndrome = 8'd0;
   logic [24:0] err_addr = 25'd0;
   logic [3:0]  err_rank = 4'd0;
   logic        scrub_active = 1'b0;
   logic        csr_valid = 1'b0, csr_write = 1'b0;
   logic [7:0]  csr_addr = 8'd0;
   logic [31:0] csr_wdata = 32'd0;
   logic        csr_ready, csr_rdata_valid, irq_ecc_corr, irq_ecc_uncorr, fatal_error;
   logic [31:0] csr_rdata;
   logic [3:0]  rank_degraded;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   ddr2_ras_csr_gen2 dut (
      .clk            (clk),
      .reset          (reset),
      .ecc_single_err (ecc_single_err),
      .ecc_double_err (ecc_double_err),
      .ecc_syndrome   (ecc_syndrome),
      .err_addr       (err_addr),
      .err_rank       (err_rank),
      .scrub_active   (scrub_active),
      .csr_valid      (csr_valid),
      .csr_write      (csr_write),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_ready      (csr_ready),
      .csr_rdata_valid(csr_rdata_valid),
      .csr_rdata      (csr_rdata),
      .irq_ecc_corr   (irq_ecc_corr),
      .irq_ecc_uncorr (irq_ecc_uncorr),
      .rank_degraded  (rank_degraded),
      .fatal_error    (fatal_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [40];
   int   nvec = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int unsigned k);
      while (cyc < k) tick();
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
      csr_valid = 1'b1;
      csr_write = 1'b0;
      csr_addr  = a;
      tick();
      csr_valid = 1'b0;
      check({name, "_rvalid"}, {31'd0, csr_rdata_valid}, 32'd1);
      check(name, csr_rdata, exp);
   endtask

   task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
      csr_valid = 1'b1;
      csr_write = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
      tick();
      csr_valid = 1'b0;
      csr_write = 1'b0;
   endtask

   task automatic err(input logic s, input logic dd, input logic [3:0] rk,
                      input logic [7:0] syn, input logic [24:0] a);
      ecc_single_err = s;
      ecc_double_err = dd;
      err_rank       = rk;
      ecc_syndrome   = syn;
      err_addr       = a;
      tick();
      ecc_single_err = 1'b0;
      ecc_double_err = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic add(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] e);
      vecs[nvec] = '{wr, a, d, e};
      nvec++;
   endtask

   function automatic logic [31:0] info_exp(input int i, input int occ);
      return {1'b1, 1'b0, 2'b00, 4'(occ), 12'd0, 4'(i % 4), 8'(16 + i)};
   endfunction

   initial begin
      int unsigned e;
      int          order [8] = '{1, 2, 3, 4, 5, 6, 7, 10};

      // Reset state, checked while reset is still held.
      tick();
      tick();
      check("ready_in_reset", {31'd0, csr_ready}, 32'd0);
      check("rvalid_in_reset", {31'd0, csr_rdata_valid}, 32'd0);
      check("fatal_in_reset", {31'd0, fatal_error}, 32'd0);
      check("irqs_in_reset", {30'd0, irq_ecc_corr, irq_ecc_uncorr}, 32'd0);
      check("degraded_in_reset", {28'd0, rank_degraded}, 32'd0);
      reset = 1'b0;
      tick();
      check("ready_after_reset", {31'd0, csr_ready}, 32'd1);

      add(0, 8'h00, 0, 0);          add(0, 8'h04, 0, 0);
      add(0, 8'h08, 0, 0);          add(0, 8'h0C, 0, 0);
      add(0, 8'h10, 0, 32'd1000);   add(0, 8'h14, 0, 0);
      add(0, 8'h18, 0, 0);          add(0, 8'h1C, 0, 32'd3);
      add(0, 8'h20, 0, 0);          add(0, 8'h24, 0, 0);
      add(0, 8'h28, 0, 0);          add(0, 8'h40, 0, 0);
      add(0, 8'h44, 0, 0);          add(0, 8'h48, 0, 0);
      add(0, 8'h4C, 0, 0);          add(0, 8'h80, 0, 0);
      add(0, 8'h8C, 0, 0);          add(0, 8'h30, 0, 0);
      add(0, 8'h50, 0, 0);
      add(1, 8'h10, 32'd5, 0);      add(0, 8'h10, 0, 32'd5);
      add(1, 8'h00, 32'hFFFF, 0);   add(0, 8'h00, 0, 0);
      add(1, 8'h1C, 32'hFFFF_FFFF, 0); add(0, 8'h1C, 0, 32'd3);
      add(1, 8'h14, 32'd7, 0);      add(0, 8'h14, 0, 32'd7);
      add(1, 8'h30, 32'h55, 0);     add(0, 8'h30, 0, 0);
      add(1, 8'h08, 32'd1, 0);      add(0, 8'h08, 0, 0);
      add(1, 8'h20, 32'hF, 0);      add(0, 8'h20, 0, 0);
      add(1, 8'h14, 32'd0, 0);      add(0, 8'h14, 0, 0);

      for (int i = 0; i < nvec; i++) begin
         if (vecs[i].wr) csr_wr(vecs[i].addr, vecs[i].data);
         else rd_chk($sformatf("vec%0d_reg%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end
      tick();
      check("rvalid_single_pulse", {31'd0, csr_rdata_valid}, 32'd0);

      scrub_active = 1'b1;
      repeat (5) tick();
      scrub_active = 1'b0;
      rd_chk("scrub_count", 8'h18, 32'd5);

      // Threshold crossing on rank 1.
      do_reset();
      csr_wr(8'h10, 32'd3);
      err(1, 0, 4'd1, 8'h01, 25'h10);
      err(1, 0, 4'd1, 8'h02, 25'h20);
      check("degraded_below_thr", {28'd0, rank_degraded}, 32'd0);
      err(1, 0, 4'd1, 8'h03, 25'h30);
      check("degraded_at_thr", {28'd0, rank_degraded}, 32'h2);
      check("irq_corr_at_n1", {31'd0, irq_ecc_corr}, 32'd0);
      tick();
      check("irq_corr_at_n2", {31'd0, irq_ecc_corr}, 32'd1);
      rd_chk("rank1_corr", 8'h44, 32'd3);
      rd_chk("total_corr_thr", 8'h00, 32'd3);
      rd_chk("status_thr", 8'h20, 32'h1);
      csr_wr(8'h1C, 32'h2);
      tick();
      check("irq_corr_masked", {31'd0, irq_ecc_corr}, 32'd0);

      // Uncorrectable error: fatal, logged context, W1C of STATUS[1].
      do_reset();
      err(0, 1, 4'd2, 8'h5A, 25'h1ABCDE);
      check("fatal_set", {31'd0, fatal_error}, 32'd1);
      check("irq_uncorr_at_n1", {31'd0, irq_ecc_uncorr}, 32'd0);
      tick();
      check("irq_uncorr_at_n2", {31'd0, irq_ecc_uncorr}, 32'd1);
      check("degraded_dbl", {28'd0, rank_degraded}, 32'h4);
      rd_chk("log_info_dbl", 8'h08, 32'hC100_025A);
      rd_chk("log_addr_dbl", 8'h0C, 32'h001A_BCDE);
      rd_chk("rank2_uncorr", 8'h88, 32'd1);
      rd_chk("total_uncorr_dbl", 8'h04, 32'd1);
      rd_chk("status_dbl", 8'h20, 32'h8000_0002);
      csr_wr(8'h20, 32'h2);
      tick();
      check("irq_uncorr_cleared", {31'd0, irq_ecc_uncorr}, 32'd0);
      check("fatal_sticky", {31'd0, fatal_error}, 32'd1);
      rd_chk("status_after_w1c", 8'h20, 32'h8000_0000);

      // Log overflow, then pop+push while full, then drain.
      do_reset();
      for (int i = 0; i < 10; i++) err(1, 0, 4'(i % 4), 8'(16 + i), 25'(256 + i));
      rd_chk("log_info_full", 8'h08, info_exp(0, 8));
      rd_chk("status_ovf", 8'h20, 32'h4);
      csr_wr(8'h20, 32'h4);
      csr_valid      = 1'b1;
      csr_write      = 1'b1;
      csr_addr       = 8'h24;
      ecc_single_err = 1'b1;
      err_rank       = 4'd2;
      ecc_syndrome   = 8'(16 + 10);
      err_addr       = 25'(256 + 10);
      tick();
      csr_valid      = 1'b0;
      csr_write      = 1'b0;
      ecc_single_err = 1'b0;
      rd_chk("status_poppush", 8'h20, 32'h0);
      for (int k = 0; k < 8; k++) begin
         rd_chk($sformatf("log_info_%0d", k), 8'h08, info_exp(order[k], 8 - k));
         rd_chk($sformatf("log_addr_%0d", k), 8'h0C, 32'(256 + order[k]));
         csr_wr(8'h24, 32'd0);
      end
      rd_chk("log_empty", 8'h08, 32'd0);
      csr_wr(8'h24, 32'd0);
      rd_chk("log_empty_pop", 8'h08, 32'd0);
      rd_chk("log_addr_empty", 8'h0C, 32'd0);
      rd_chk("total_corr_log", 8'h00, 32'd11);

      // Decay: ticks land on edges E+10, E+20, ... after the DECAY_PERIOD write at edge E.
      do_reset();
      csr_wr(8'h14, 32'd10);
      e = cyc;
      err(1, 0, 4'd0, 8'h01, 25'h1);
      err(1, 0, 4'd0, 8'h02, 25'h2);
      wait_cyc(e + 5);
      rd_chk("decay_start", 8'h40, 32'd2);
      wait_cyc(e + 14);
      rd_chk("decay_tick1", 8'h40, 32'd1);
      wait_cyc(e + 24);
      rd_chk("decay_tick2", 8'h40, 32'd0);
      wait_cyc(e + 25);
      err(1, 0, 4'd0, 8'h03, 25'h3);
      wait_cyc(e + 29);
      err(1, 0, 4'd0, 8'h04, 25'h4);
      wait_cyc(e + 34);
      rd_chk("decay_inc_same", 8'h40, 32'd1);
      wait_cyc(e + 44);
      rd_chk("decay_tick4", 8'h40, 32'd0);
      rd_chk("total_no_decay", 8'h00, 32'd4);

      // Coincident single+double, CTRL clear with coincident error, out-of-range rank.
      do_reset();
      err(1, 1, 4'd0, 8'h33, 25'h77);
      rd_chk("both_total_corr", 8'h00, 32'd1);
      rd_chk("both_total_uncorr", 8'h04, 32'd1);
      rd_chk("both_log_info", 8'h08, 32'hC100_0033);
      rd_chk("both_log_addr", 8'h0C, 32'h77);
      rd_chk("both_status", 8'h20, 32'h8000_000A);
      rd_chk("both_rank0_corr", 8'h40, 32'd1);
      rd_chk("both_rank0_uncorr", 8'h80, 32'd1);
      csr_valid      = 1'b1;
      csr_write      = 1'b1;
      csr_addr       = 8'h28;
      csr_wdata      = 32'd1;
      ecc_single_err = 1'b1;
      err_rank       = 4'd0;
      ecc_syndrome   = 8'h44;
      err_addr       = 25'h88;
      tick();
      csr_valid      = 1'b0;
      csr_write      = 1'b0;
      ecc_single_err = 1'b0;
      rd_chk("clr_total_corr", 8'h00, 32'd1);
      rd_chk("clr_total_uncorr", 8'h04, 32'd0);
      rd_chk("clr_rank0_corr", 8'h40, 32'd1);
      rd_chk("clr_rank0_uncorr", 8'h80, 32'd0);
      err(1, 0, 4'd9, 8'h55, 25'h99);
      rd_chk("oor_total_corr", 8'h00, 32'd2);
      rd_chk("oor_rank0_corr", 8'h40, 32'd1);
      check("degraded_rank0", {28'd0, rank_degraded}, 32'h1);

      // Reset on the edge a read is accepted: no read data, log flushed.
      csr_valid = 1'b1;
      csr_write = 1'b0;
      csr_addr  = 8'h08;
      reset     = 1'b1;
      tick();
      csr_valid = 1'b0;
      check("read_dropped_by_reset", {31'd0, csr_rdata_valid}, 32'd0);
      check("fatal_cleared_by_reset", {31'd0, fatal_error}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      rd_chk("log_flushed", 8'h08, 32'd0);
      rd_chk("total_after_reset", 8'h00, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
